// File: rtl/aes256_pkg.sv
// Shared types and round-count constants for the AES iterative datapath controllers.
package aes256_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        FINAL,
        DONE
    } round_state_t;

    localparam int unsigned NR_AES256 = 14;
    localparam int unsigned NR_AES192 = 12;
    localparam int unsigned NR_AES128 = 10;

endpackage

// File: rtl/aes256_round_ctrl.sv
// Round sequencer for the AES iterative datapath: LOAD, NR-1 full rounds, FINAL, then DONE.
// Define AES_KEY_STALL_EN to add key_valid and hold the sequence while round keys are late.
module aes256_round_ctrl
    import aes256_pkg::*;
#(
    parameter int unsigned NR = NR_AES256,
    parameter int unsigned RW = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic          abort,
`ifdef AES_KEY_STALL_EN
    input  logic          key_valid,
`endif
    output logic          reg_wr_en,
    output logic          load_sel,
    output logic [RW-1:0] round,
    output logic          last_round,
    output logic          busy
);

    localparam logic [RW-1:0] RoundFinal = RW'(NR);
    localparam logic [RW-1:0] RoundLastFull = RW'(NR - 1);
    localparam logic [RW-1:0] RoundOne = RW'(1);

    round_state_t  state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    logic          adv;

`ifdef AES_KEY_STALL_EN
    assign adv = key_valid;
`else
    assign adv = 1'b1;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    // abort outranks every transition, including a new block in IDLE
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        if (abort) begin
            state_d = IDLE;
            round_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_d = LOAD;
                        round_d = '0;
                    end
                end
                LOAD: begin
                    if (adv) begin
                        state_d = ROUND;
                        round_d = RoundOne;
                    end
                end
                ROUND: begin
                    if (adv) begin
                        if (round_q == RoundLastFull) begin
                            state_d = FINAL;
                            round_d = RoundFinal;
                        end else begin
                            round_d = round_q + RoundOne;
                        end
                    end
                end
                FINAL: begin
                    if (adv) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        round_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    round_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        reg_wr_en  = 1'b0;
        load_sel   = 1'b0;
        busy       = 1'b0;
        round      = round_q;
        last_round = (round_q == RoundFinal);
        unique case (state_q)
            IDLE: in_ready = 1'b1;
            LOAD: begin
                reg_wr_en = adv;
                load_sel  = 1'b1;
                busy      = 1'b1;
            end
            ROUND: begin
                reg_wr_en = adv;
                busy      = 1'b1;
            end
            FINAL: begin
                reg_wr_en = adv;
                busy      = 1'b1;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

endmodule
